// File: rtl/pipeline_pkg.sv
// Shared front-end pipeline types: the IF/ID payload and the canonical NOP.
package pipeline_pkg;

  localparam int FETCH_PC_W = 9;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Generic synchronous FIFO with clear; head is read straight from storage.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push) wr_d = ptr_inc(wr_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: credit-limited IMEM requests tagged with an epoch bit,
// stale-response filtering on redirect, and a small buffer feeding IF/ID.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int PC_W      = FETCH_PC_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [31:0]     redirect_pc_i,
  input  logic            stall_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [PC_W-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            if_valid_o,
  output logic [PC_W-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  output logic            flush_o,
  output logic            misalign_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic            epoch;
    logic [PC_W-1:0] pc;
  } tag_t;

  logic [PC_W-1:0]  fpc_q, fpc_d;
  logic             epoch_q, epoch_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             flush_q, misalign_q;

  logic [CNT_W-1:0] buf_cnt;
  logic             buf_empty;
  logic             req_fire, rsp_wr, buf_pop;
  tag_t             tag_in, tag_head;
  fetch_entry_t     ent_in, ent_head;

  logic [CNT_W-1:0] unused_tag_cnt;
  logic             unused_tag_empty, unused_tag_full, unused_buf_full, unused_rpc;

  // Credits count both in-flight requests and buffered entries, so every
  // response that survives the epoch check is guaranteed a free slot.
  assign imem_req_valid_o = !reset &&
    (({1'b0, out_q} + {1'b0, buf_cnt}) < (CNT_W + 1)'(BUF_DEPTH));
  assign imem_req_addr_o  = fpc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign tag_in  = '{epoch: epoch_q, pc: fpc_q};
  assign rsp_wr  = imem_rsp_valid_i && (tag_head.epoch == epoch_q) && !redirect_i;
  assign ent_in  = '{pc: tag_head.pc, instr: imem_rsp_data_i};
  assign buf_pop = !buf_empty && !stall_i && !redirect_i;

  assign if_valid_o = !buf_empty;
  assign if_pc_o    = buf_empty ? '0 : ent_head.pc;
  assign if_instr_o = buf_empty ? '0 : ent_head.instr;
  assign flush_o    = flush_q;
  assign misalign_o = misalign_q;
  assign unused_rpc = ^redirect_pc_i[31:PC_W];

  fetch_buffer #(.DEPTH(BUF_DEPTH), .WIDTH($bits(tag_t))) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (req_fire),
    .pop_i   (imem_rsp_valid_i),
    .clear_i (1'b0),
    .data_i  (tag_in),
    .head_o  (tag_head),
    .count_o (unused_tag_cnt),
    .empty_o (unused_tag_empty),
    .full_o  (unused_tag_full)
  );

  fetch_buffer #(.DEPTH(BUF_DEPTH), .WIDTH($bits(fetch_entry_t))) u_data_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_wr),
    .pop_i   (buf_pop),
    .clear_i (redirect_i),
    .data_i  (ent_in),
    .head_o  (ent_head),
    .count_o (buf_cnt),
    .empty_o (buf_empty),
    .full_o  (unused_buf_full)
  );

  always_comb begin
    fpc_d   = fpc_q;
    epoch_d = epoch_q ^ redirect_i;
    out_d   = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid_i);
    if (redirect_i)    fpc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
    else if (req_fire) fpc_d = fpc_q + PC_W'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q      <= '0;
      epoch_q    <= 1'b0;
      out_q      <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      epoch_q    <= epoch_d;
      out_q      <= out_d;
      flush_q    <= redirect_i;
      misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench: directed redirect/stall/reset scenarios against an in-order IMEM model.
module tb_fetch_unit;

  localparam int PC_W = 9;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            redirect_i = 1'b0;
  logic [31:0]     redirect_pc_i = '0;
  logic            stall_i = 1'b0;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i = 1'b1;
  logic [PC_W-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i = 1'b0;
  logic [31:0]     imem_rsp_data_i = '0;
  logic            if_valid_o;
  logic [PC_W-1:0] if_pc_o;
  logic [31:0]     if_instr_o;
  logic            flush_o;
  logic            misalign_o;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 1;
  int cyc   = 0;

  typedef struct {
    logic [PC_W-1:0] a;
    int              due;
  } pend_t;

  pend_t           pend[$];
  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] mon_e;

  fetch_unit #(.PC_W(PC_W), .BUF_DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .stall_i          (stall_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .if_instr_o       (if_instr_o),
    .flush_o          (flush_o),
    .misalign_o       (misalign_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [PC_W-1:0] a);
    return 32'hBEEF_0000 | 32'(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout with %0d expected fetches outstanding", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // IMEM model: in order, responds lat cycles after accept, reset with the DUT.
  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
      imem_rsp_valid_i = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = word(pend[0].a);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid_i = 1'b0;
      end
      if (imem_req_valid_o && imem_req_ready_i)
        pend.push_back('{a: imem_req_addr_o, due: cyc + lat});
    end
  end

  // Monitor: every instruction consumed by decode is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset && if_valid_o && !stall_i && !redirect_i && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("if_pc", 32'(if_pc_o), 32'(mon_e));
      chk("if_instr", if_instr_o, word(mon_e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_req_valid", imem_req_valid_o, 0);
    chk("rst_if_valid", if_valid_o, 0);
    chk("rst_if_pc", 32'(if_pc_o), 0);
    chk("rst_if_instr", if_instr_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_misalign", misalign_o, 0);

    // Linear fetch, first-valid latency
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h004);
    reset = 1'b0;
    chk("lat_c0", if_valid_o, 0);
    tick();
    chk("lat_c1", if_valid_o, 0);
    tick();
    chk("lat_c2", if_valid_o, 1);
    chk("first_pc", 32'(if_pc_o), 0);

    // Stall at pc 8 for 5 cycles
    n = 0;
    while (!(if_valid_o && if_pc_o == 9'h008) && n < 50) begin
      tick();
      n++;
    end
    chk("reach_pc8", 32'(if_pc_o), 32'h8);
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", if_valid_o, 1);
      chk("stall_pc", 32'(if_pc_o), 32'h8);
      chk("stall_instr", if_instr_o, word(9'h008));
      if (i < 4) tick();
    end
    chk("stall_no_credit", imem_req_valid_o, 0);
    exp_q.push_back(9'h008);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h010);
    exp_q.push_back(9'h014);
    tick();
    stall_i = 1'b0;
    wait_drain("stall_resume");

    // Redirect to 0x40 with two requests in flight, 3-cycle IMEM
    reset = 1'b1;
    tick();
    tick();
    lat = 3;
    reset = 1'b0;
    tick();
    tick();
    chk("two_outstanding", imem_req_valid_o, 0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    exp_q.push_back(9'h040);
    exp_q.push_back(9'h044);
    exp_q.push_back(9'h048);
    tick();
    redirect_i = 1'b0;
    chk("r40_flush", flush_o, 1);
    chk("r40_misalign", misalign_o, 0);
    chk("r40_stale0", if_valid_o, 0);
    tick();
    chk("r40_flush_once", flush_o, 0);
    chk("r40_stale1", if_valid_o, 0);
    wait_drain("redirect_40");

    // Misaligned redirect and PC wrap
    lat = 1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h1F2;
    exp_q.push_back(9'h1F0);
    exp_q.push_back(9'h1F4);
    exp_q.push_back(9'h1F8);
    exp_q.push_back(9'h1FC);
    exp_q.push_back(9'h000);
    tick();
    redirect_i = 1'b0;
    chk("mis_flush", flush_o, 1);
    chk("mis_misalign", misalign_o, 1);
    tick();
    chk("mis_misalign_once", misalign_o, 0);
    chk("mis_flush_once", flush_o, 0);
    wait_drain("wrap");

    // Back-to-back redirects with a response landing in each cycle
    reset = 1'b1;
    tick();
    tick();
    lat = 2;
    reset = 1'b0;
    n = 0;
    while (!(pend.size() >= 2 && pend[0].due == cyc && pend[1].due == cyc + 1) && n < 50) begin
      tick();
      n++;
    end
    chk("b2b_setup", n < 50, 1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h80;
    tick();
    chk("b2b_flush0", flush_o, 1);
    redirect_pc_i = 32'h100;
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h104);
    exp_q.push_back(9'h108);
    tick();
    redirect_i = 1'b0;
    chk("b2b_flush1", flush_o, 1);
    tick();
    chk("b2b_flush_end", flush_o, 0);
    wait_drain("b2b");

    // Reset mid-stream with buffer full
    stall_i = 1'b1;
    repeat (6) tick();
    chk("full_no_credit", imem_req_valid_o, 0);
    chk("full_valid", if_valid_o, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_req_valid", imem_req_valid_o, 0);
    chk("mid_rst_if_valid", if_valid_o, 0);
    chk("mid_rst_if_pc", 32'(if_pc_o), 0);
    chk("mid_rst_if_instr", if_instr_o, 0);
    chk("mid_rst_flush", flush_o, 0);
    chk("mid_rst_misalign", misalign_o, 0);
    stall_i = 1'b0;
    lat = 1;
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h004);
    exp_q.push_back(9'h008);
    tick();
    reset = 1'b0;
    chk("restart_addr", 32'(imem_req_addr_o), 0);
    wait_drain("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
